regs_32x32: RTL and testbench

32-entry × 32-bit register file with two registered read ports and a background dump sequencer that streams every register out over a valid/ready port. It is the read side of the datapath: `Reg_32`-style loaded registers are written here and read back by the datapath and the display/debug logic. Register 0 reads as zero.

---
 rtl/regs_pkg.sv | 16 +
 rtl/regs_dump_fsm.sv | 66 ++++++
 rtl/regs_32x32.sv | 68 ++++++
 tb/tb_regs_32x32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// regs_32x32 shared definitions: default sizes, dump states, last index.
// Imported by the register file top and its dump sequencer.
package regs_pkg;

  localparam int WIDTH_D  = 32;
  localparam int NREGS_D  = 32;
  localparam int AW_D     = 5;
  localparam int LAST_IDX = NREGS_D - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regs_dump_fsm.sv
// Dump sequencer: walks idx 0..LAST, one READ + one HOLD per element.
// Ports: start/ready in; busy/valid/idx out; rd_addr/cap to storage.
module regs_dump_fsm
  import regs_pkg::*;
#(
  parameter int AW   = AW_D,
  parameter int LAST = LAST_IDX
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          start,
  input  logic          ready,
  output logic          busy,
  output logic          valid,
  output logic [AW-1:0] idx,
  output logic [AW-1:0] rd_addr,
  output logic          cap
);

  localparam logic [AW-1:0] LAST_A = AW'(LAST);

  dump_state_t   state;
  dump_state_t   state_nxt;
  logic [AW-1:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end
      end
      READ: state_nxt = HOLD;
      HOLD: begin
        if (ready) begin
          if (idx == LAST_A) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = READ;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign valid   = (state == HOLD);
  assign cap     = (state == READ);
  assign rd_addr = idx;

endmodule

// File: rtl/regs_32x32.sv
// 32x32 register file: two registered read ports plus a dump port.
// Ports: we/waddr/wdata write; ra_*/rb_* reads; dump_* valid/ready stream.
module regs_32x32
  import regs_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int NREGS = NREGS_D,
  parameter int AW    = AW_D
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data
);

  logic [WIDTH-1:0] mem [NREGS];
  logic [AW-1:0]    d_addr;
  logic             d_cap;

  // Write-first: a same-cycle write to the read address wins.
  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (we && waddr == a) return wdata;
    return mem[a];
  endfunction

  regs_dump_fsm #(
    .AW   (AW),
    .LAST (NREGS - 1)
  ) u_fsm (
    .clk     (clk),
    .clear_n (clear_n),
    .start   (dump_start),
    .ready   (dump_ready),
    .busy    (dump_busy),
    .valid   (dump_valid),
    .idx     (dump_idx),
    .rd_addr (d_addr),
    .cap     (d_cap)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      mem       <= '{default: '0};
      ra_data   <= '0;
      rb_data   <= '0;
      dump_data <= '0;
    end else begin
      if (we && waddr != '0) mem[waddr] <= wdata;
      ra_data <= rd(ra_addr);
      rb_data <= rd(rb_addr);
      // Captured once per element, so HOLD-time writes leave it intact.
      if (d_cap) dump_data <= rd(d_addr);
    end
  end

endmodule

// File: tb/tb_regs_32x32.sv
// Self-checking bench for regs_32x32: vector table, random vs model,
// dump / backpressure / mid-dump reset sequences.
module tb_regs_32x32;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  ra_addr = '0;
  logic [31:0] ra_data;
  logic [4:0]  rb_addr = '0;
  logic [31:0] rb_data;
  logic        dump_start = 1'b0;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  regs_32x32 dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .ra_addr    (ra_addr),
    .ra_data    (ra_data),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference read: zero register, write-first, else stored value.
  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return mdl[a];
  endfunction

  task automatic mdl_write();
    if (we && waddr != 0) mdl[waddr] = wdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    mdl_write();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] ea, eb;
    logic [31:0] qi [$];
    logic [31:0] qd [$];
    int cyc, first, n;

    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    vecs[0] = '{1'b1, 5'd0,  32'hAAAAAAAA, 5'd0,  5'd0,  32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd5,  32'h55555555, 5'd3,  5'd4,  32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                32'h55555555, 32'h55555555};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,
                32'hA5A5A5A5, 32'h55555555};
    vecs[5] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd7,
                32'h11111111, 32'h11111111};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,
                32'h11111111, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30,
                32'hFFFFFFFF, 32'h0};

    // Reset
    clear_n = 1'b0;
    step(); step();
    clear_n = 1'b1;
    check("rst_busy", {31'h0, dump_busy}, 32'h0);
    check("rst_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_idx", {27'h0, dump_idx}, 32'h0);
    check("rst_ddata", dump_data, 32'h0);
    check("rst_ra", ra_data, 32'h0);
    check("rst_rb", rb_data, 32'h0);

    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      step();
      check("rst_rd_a", ra_data, 32'h0);
      check("rst_rd_b", rb_data, 32'h0);
    end

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      ra_addr = vecs[i].ra; rb_addr = vecs[i].rb;
      step();
      mdl_write();
      check($sformatf("vec%0d_a", i), ra_data, vecs[i].ea);
      check($sformatf("vec%0d_b", i), rb_data, vecs[i].eb);
    end
    we = 1'b0;

    // Random traffic against the array model
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      ra_addr = 5'($urandom_range(0, 7));
      rb_addr = 5'($urandom_range(0, 31));
      ea = ref_rd(ra_addr);
      eb = ref_rd(rb_addr);
      step();
      mdl_write();
      check("rnd_a", ra_data, ea);
      check("rnd_b", rb_data, eb);
    end
    we = 1'b0;

    // Full dump
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("dmp_busy_on", {31'h0, dump_busy}, 32'h1);
    check("dmp_valid_read", {31'h0, dump_valid}, 32'h0);
    cyc = 0; first = -1;
    while (dump_busy && cyc < 100) begin
      if (cyc == 10) dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      cyc++;
      if (dump_valid) begin
        if (first < 0) first = cyc;
        qi.push_back({27'h0, dump_idx});
        qd.push_back(dump_data);
      end
    end
    check("dmp_first_valid", 32'(first), 32'd1);
    check("dmp_len_cycles", 32'(cyc), 32'd64);
    check("dmp_count", 32'(qi.size()), 32'd32);
    for (int k = 0; k < 32 && k < qi.size(); k++) begin
      check($sformatf("dmp_idx%0d", k), qi[k], 32'(k));
      check($sformatf("dmp_dat%0d", k), qd[k], 32'(k) * 32'h01010101);
    end
    step(); step();
    check("dmp_end_busy", {31'h0, dump_busy}, 32'h0);
    check("dmp_no_wrap", {27'h0, dump_idx}, 32'd31);

    // Backpressure with snapshot
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    n = 0;
    while (!(dump_valid && dump_idx == 5'd3) && n < 40) begin
      step(); n++;
    end
    check("bp_reach3", {31'h0, dump_valid && dump_idx == 5'd3}, 32'h1);
    dump_ready = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'h5A5A5A5A;
    for (int k = 0; k < 5; k++) begin
      step();
      mdl_write();
      check("bp_valid", {31'h0, dump_valid}, 32'h1);
      check("bp_idx", {27'h0, dump_idx}, 32'd3);
      check("bp_snap", dump_data, 32'h03030303);
    end
    we = 1'b0;
    dump_ready = 1'b1;
    step();
    check("bp_bubble", {31'h0, dump_valid}, 32'h0);
    check("bp_idx4", {27'h0, dump_idx}, 32'd4);
    step();
    check("bp_valid4", {31'h0, dump_valid}, 32'h1);
    check("bp_dat4", dump_data, 32'h04040404);
    ra_addr = 5'd3;
    step();
    check("bp_r3_new", ra_data, 32'h5A5A5A5A);

    // Reset during HOLD at idx 10
    n = 0;
    while (!(dump_valid && dump_idx == 5'd10) && n < 40) begin
      step(); n++;
    end
    check("clr_reach10", {31'h0, dump_valid && dump_idx == 5'd10}, 32'h1);
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    check("clr_valid", {31'h0, dump_valid}, 32'h0);
    check("clr_busy", {31'h0, dump_busy}, 32'h0);
    check("clr_idx", {27'h0, dump_idx}, 32'h0);
    check("clr_ddata", dump_data, 32'h0);
    dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(i);
      step();
      check("clr_rd_a", ra_data, 32'h0);
      check("clr_rd_b", rb_data, 32'h0);
    end
    check("clr_stay_idle", {31'h0, dump_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
